// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_pkg
// Brief    : Shared constants and helpers for the scan-display FIFO block:
//            blank segment pattern, hex-to-7-segment decode and clog2.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // All segments off (active-low bank).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Ceiling log2 used for pointer and counter widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} patterns for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_scan_queue_btn_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse
// Brief    : Raw button conditioning: 2-FF synchronizer, counter debouncer
//            and rising-edge one-shot. A held button yields a single pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_pulse
    import fifo_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int c_CW = (clog2(DEB_CYC) < 1) ? 1 : clog2(DEB_CYC);

    logic [1:0]      r_sync;
    logic            r_level;
    logic            r_level_d;
    logic [c_CW-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_btn};
    end

    // Flip the debounced level only after DEB_CYC consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync[1] == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CW'(DEB_CYC - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + c_CW'(1);
        end
    end

    // Delayed copy of the level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_level_d <= 1'b0;
        else     r_level_d <= r_level;
    end

    assign o_pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/fifo_scan_queue.sv
`default_nettype none
// ============================================================================
// Module   : fifo_scan_queue
// Brief    : Button-driven circular FIFO with count-based occupancy and a
//            multiplexed active-low 7-segment view of its contents. The
//            decimal point marks the head entry.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_scan_queue
    import fifo_pkg::*;
#(
    parameter int  W        = 4,
    parameter int  DEPTH    = 8,
    parameter int  NDIG     = 8,
    parameter int  DEB_CYC  = 16,
    parameter int  SCAN_DIV = 1000,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_btn,
    input  logic            pop_btn,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    dout,
    output logic            pop_valid,
    output logic            empty,
    output logic            full,
    output logic [AW:0]     count,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int c_PW = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);

    logic            w_push_pulse;
    logic            w_pop_pulse;
    logic            w_push_ok;
    logic            w_pop_ok;

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    logic [W-1:0]    r_dout;
    logic            r_pop_valid;

    logic [c_PW-1:0] r_pre;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_rel;
    logic            w_occ;
    logic [NDIG-1:0] w_an;
    logic [6:0]      w_seg;
    logic            w_dp;
    logic [NDIG-1:0] r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    btn_pulse #(.DEB_CYC(DEB_CYC)) u_push_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (push_btn),
        .o_pulse (w_push_pulse)
    );

    btn_pulse #(.DEB_CYC(DEB_CYC)) u_pop_btn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (pop_btn),
        .o_pulse (w_pop_pulse)
    );

    // A push into a full FIFO is still legal when a pop frees a slot in the
    // same cycle; a pop from empty is never bypassed by a concurrent push.
    assign w_pop_ok  = w_pop_pulse & ~empty;
    assign w_push_ok = w_push_pulse & (~full | w_pop_ok);

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));

    // Storage write on accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_tail] <= din;
        end
    end

    // Pointers roll over naturally at DEPTH (power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + AW'(1);
            if (w_pop_ok)  r_head <= r_head + AW'(1);
        end
    end

    // Occupancy tracks push/pop; a simultaneous pair leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Popped word is held until the next pop; pop_valid pulses alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ok;
            if (w_pop_ok) r_dout <= r_mem[r_head];
        end
    end

    // Prescaler and digit index for the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_PW'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + AW'(1);
        end else begin
            r_pre <= r_pre + c_PW'(1);
        end
    end

    // Decode the current slot: lit only if it lies inside head..head+count-1.
    always_comb begin
        w_rel = r_idx - r_head;
        w_occ = ({1'b0, w_rel} < r_count);
        w_an  = '1;
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (w_occ) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_idx == AW'(i)) w_an[i] = 1'b0;
            end
            w_seg = hex_to_seg(r_mem[r_idx][3:0]);
            w_dp  = (r_idx != r_head);
        end
    end

    // Register the display pins so they never glitch between digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign dout      = r_dout;
    assign pop_valid = r_pop_valid;
    assign count     = r_count;
    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_fifo_scan_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_scan_queue
// Brief    : Self-checking bench for fifo_scan_queue with a queue-based
//            reference model and randomized button traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_scan_queue;

    localparam int W        = 4;
    localparam int DEPTH    = 8;
    localparam int NDIG     = 10;
    localparam int DEB_CYC  = 4;
    localparam int SCAN_DIV = 3;
    localparam int AW       = 3;

    logic            clk;
    logic            rst;
    logic            push_btn;
    logic            pop_btn;
    logic [W-1:0]    din;
    logic [W-1:0]    dout;
    logic            pop_valid;
    logic            empty;
    logic            full;
    logic [AW:0]     count;
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp;

    fifo_scan_queue #(
        .W        (W),
        .DEPTH    (DEPTH),
        .NDIG     (NDIG),
        .DEB_CYC  (DEB_CYC),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_btn  (push_btn),
        .pop_btn   (pop_btn),
        .din       (din),
        .dout      (dout),
        .pop_valid (pop_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0]    q[$];
    int              m_head;
    int              n_scan;
    bit              h_push[$];
    bit              h_pop[$];
    bit              lvl_push, lvl_pop;
    bit              pp_push, pp_pop;
    logic [W-1:0]    exp_dout;
    bit              exp_pv;
    logic [NDIG-1:0] exp_an;
    logic [6:0]      exp_seg;
    bit              exp_dp;

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        h_push.delete();
        h_pop.delete();
        for (int i = 0; i < DEB_CYC + 2; i++) begin
            h_push.push_back(1'b0);
            h_pop.push_back(1'b0);
        end
        m_head = 0; n_scan = 0;
        lvl_push = 0; lvl_pop = 0; pp_push = 0; pp_pop = 0;
        exp_dout = '0; exp_pv = 0;
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1;
    endtask

    // Debounced level: takes value v once the last DEB_CYC synchronized
    // samples (raw delayed by two edges) all equal v.
    function automatic bit settle(input bit h[$], input bit lvl);
        bit v;
        v = h[0];
        for (int i = 1; i < DEB_CYC; i++) if (h[i] != v) return lvl;
        return v;
    endfunction

    task automatic model_edge(input bit rp, input bit rpo, input logic [W-1:0] d);
        int idx, rel;
        bit pop_ok, push_ok, nl;
        // display registered from state before this edge
        idx = (n_scan / SCAN_DIV) % DEPTH;
        rel = (idx - m_head + DEPTH) % DEPTH;
        exp_an = '1; exp_seg = 7'h7F; exp_dp = 1;
        if (rel < q.size()) begin
            exp_an[idx] = 1'b0;
            exp_seg     = seg_tab[q[rel][3:0]];
            exp_dp      = (rel != 0);
        end
        n_scan++;
        // queue actions from pulses that were live before this edge
        pop_ok  = pp_pop && (q.size() > 0);
        push_ok = pp_push && ((q.size() < DEPTH) || pop_ok);
        exp_pv  = pop_ok;
        if (pop_ok) begin
            exp_dout = q.pop_front();
            m_head   = (m_head + 1) % DEPTH;
        end
        if (push_ok) q.push_back(d);
        // button conditioning
        h_push.push_back(rp);  void'(h_push.pop_front());
        h_pop.push_back(rpo);  void'(h_pop.pop_front());
        nl = settle(h_push, lvl_push); pp_push = nl && !lvl_push; lvl_push = nl;
        nl = settle(h_pop,  lvl_pop);  pp_pop  = nl && !lvl_pop;  lvl_pop  = nl;
    endtask

    task automatic check_all();
        chk("count",     int'(count),     q.size());
        chk("empty",     int'(empty),     int'(q.size() == 0));
        chk("full",      int'(full),      int'(q.size() == DEPTH));
        chk("dout",      int'(dout),      int'(exp_dout));
        chk("pop_valid", int'(pop_valid), int'(exp_pv));
        chk("an",        int'(an),        int'(exp_an));
        chk("seg",       int'(seg),       int'(exp_seg));
        chk("dp",        int'(dp),        int'(exp_dp));
    endtask

    task automatic tick();
        bit rp, rpo, rr;
        logic [W-1:0] d;
        rp = push_btn; rpo = pop_btn; rr = rst; d = din;
        @(posedge clk);
        if (rr) model_reset();
        else    model_edge(rp, rpo, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input bit dp_push, input bit dp_pop, input logic [W-1:0] d,
                         input int hi, input int lo);
        din = d; push_btn = dp_push; pop_btn = dp_pop;
        repeat (hi) tick();
        push_btn = 1'b0; pop_btn = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_an(input logic [NDIG-1:0] target);
        int k;
        k = 0;
        while (an != target && k < 3 * SCAN_DIV * DEPTH) begin
            tick();
            k++;
        end
        chk("scan_reach", int'(an), int'(target));
    endtask

    localparam int HI = DEB_CYC + 3;
    localparam int LO = DEB_CYC + 3;

    initial begin
        rst = 1'b1; push_btn = 1'b0; pop_btn = 1'b0; din = '0;
        model_reset();
        tick(); tick();
        // reset state, literal
        chk("rst_an",    int'(an),    10'h3FF);
        chk("rst_seg",   int'(seg),   7'h7F);
        chk("rst_dp",    int'(dp),    1);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        rst = 1'b0;
        tick();

        // pop when empty is ignored
        press(0, 1, 4'h0, HI, LO);
        chk("empty_pop_count", int'(count), 0);

        // push 3, A, 5 and look at the scan
        press(1, 0, 4'h3, HI, LO);
        press(1, 0, 4'hA, HI, LO);
        press(1, 0, 4'h5, HI, LO);
        chk("three_count", int'(count), 3);
        wait_an(10'h3FE);
        chk("idx0_seg", int'(seg), 7'h30);
        chk("idx0_dp",  int'(dp),  0);
        wait_an(10'h3FD);
        chk("idx1_seg", int'(seg), 7'h08);
        chk("idx1_dp",  int'(dp),  1);
        wait_an(10'h3FB);
        chk("idx2_seg", int'(seg), 7'h12);

        // drain, then fill with 1..8
        repeat (3) press(0, 1, 4'h0, HI, LO);
        chk("drain_dout", int'(dout), 5);
        for (int i = 1; i <= 8; i++) press(1, 0, 4'(i), HI, LO);
        chk("fill_full",  int'(full),  1);
        chk("fill_count", int'(count), 8);
        press(1, 0, 4'h9, HI, LO);
        chk("ninth_count", int'(count), 8);

        // pop 3, push 3 more across the wrap
        repeat (3) press(0, 1, 4'h0, HI, LO);
        chk("pop3_dout", int'(dout), 3);
        press(1, 0, 4'h9, HI, LO);
        press(1, 0, 4'hA, HI, LO);
        press(1, 0, 4'hB, HI, LO);
        chk("wrap_count", int'(count), 8);

        // simultaneous push+pop while full
        press(1, 1, 4'hC, HI, LO);
        chk("both_full_count", int'(count), 8);
        chk("both_full_dout",  int'(dout),  4);
        repeat (8) press(0, 1, 4'h0, HI, LO);
        chk("drain_last", int'(dout), 12);
        chk("drain_empty", int'(empty), 1);

        // simultaneous push+pop while empty: push only
        press(1, 1, 4'hD, HI, LO);
        chk("both_empty_count", int'(count), 1);
        chk("both_empty_dout",  int'(dout),  12);

        // bounce shorter than the debounce window
        press(1, 0, 4'h7, DEB_CYC - 1, LO);
        press(0, 1, 4'h7, DEB_CYC - 2, LO);
        chk("glitch_count", int'(count), 1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4)
                press(1, 0, 4'($urandom), $urandom_range(DEB_CYC, DEB_CYC + 5), $urandom_range(DEB_CYC, DEB_CYC + 5));
            else if (op < 7)
                press(0, 1, 4'($urandom), $urandom_range(DEB_CYC, DEB_CYC + 5), $urandom_range(DEB_CYC, DEB_CYC + 5));
            else if (op < 9)
                press(1, 1, 4'($urandom), $urandom_range(DEB_CYC, DEB_CYC + 5), $urandom_range(DEB_CYC, DEB_CYC + 5));
            else
                press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom),
                      $urandom_range(1, DEB_CYC - 1), $urandom_range(DEB_CYC, DEB_CYC + 5));
        end

        // asynchronous reset mid-scan with 4 entries
        while (count > 0) press(0, 1, 4'h0, HI, LO);
        for (int i = 0; i < 4; i++) press(1, 0, 4'(i + 6), HI, LO);
        repeat (5) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_an",    int'(an),    10'h3FF);
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        check_all();
        tick(); tick();
        rst = 1'b0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
